// File: rtl/riscv_fetch_ctrl.sv
// Fetch sequencer: one outstanding imem request, 1-entry decode buffer; >=3 cycles/instruction.
// Redirects override all states; decode backpressure holds the buffer stable and stalls new requests.
package riscv_fetch_pkg;
    typedef enum logic [1:0] {
        PC_HOLD     = 2'd0,
        PC_PLUS4    = 2'd1,
        PC_J_TARGET = 2'd2
    } pc_sel_t;
endpackage

module riscv_fetch_ctrl
    import riscv_fetch_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            x_reset,
    input  logic [XLEN-1:0] pc_in,
    output pc_sel_t         pc_sel,
    output logic [XLEN-1:0] jump_target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic            timeout_err,
    output logic [31:0]     fetch_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam logic [31:0] TO_LIM = 32'(TIMEOUT);

    state_t          state_q, state_d;
    logic            drop_q, drop_d;
    logic [31:0]     wait_cnt_q, wait_cnt_d;
    logic [XLEN-1:0] req_pc_q;
    logic            inst_valid_q, inst_valid_d;
    logic [XLEN-1:0] inst_data_q, inst_pc_q;
    logic            timeout_err_q;
    logic [31:0]     fetch_count_q;

    logic            latch_req;
    logic            deliver;
    logic            fetch_inc;
    logic            set_timeout;

    always_ff @(posedge clk or posedge x_reset) begin
        if (x_reset) begin
            state_q       <= ST_IDLE;
            drop_q        <= 1'b0;
            wait_cnt_q    <= '0;
            req_pc_q      <= '0;
            inst_valid_q  <= 1'b0;
            inst_data_q   <= '0;
            inst_pc_q     <= '0;
            timeout_err_q <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q      <= state_d;
            drop_q       <= drop_d;
            wait_cnt_q   <= wait_cnt_d;
            inst_valid_q <= inst_valid_d;
            if (latch_req) begin
                req_pc_q <= pc_in;
            end
            if (deliver) begin
                inst_data_q <= imem_rsp_data;
                inst_pc_q   <= req_pc_q;
            end
            if (set_timeout) begin
                timeout_err_q <= 1'b1;
            end
            if (fetch_inc) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        drop_d         = drop_q;
        wait_cnt_d     = wait_cnt_q;
        inst_valid_d   = inst_valid_q;
        pc_sel         = PC_HOLD;
        jump_target    = '0;
        imem_req_valid = 1'b0;
        imem_req_addr  = pc_in;
        latch_req      = 1'b0;
        deliver        = 1'b0;
        fetch_inc      = 1'b0;
        set_timeout    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                imem_req_valid = !redirect_valid;
                if (imem_req_valid && imem_req_ready) begin
                    pc_sel    = PC_PLUS4;
                    latch_req = 1'b1;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    // A pending drop swallows this response and refetches from the new PC.
                    deliver    = !drop_q;
                    state_d    = drop_q ? ST_REQ : ST_HOLD;
                    drop_d     = 1'b0;
                    wait_cnt_d = '0;
                end else begin
                    if (wait_cnt_q != '1) begin
                        wait_cnt_d = wait_cnt_q + 32'd1;
                    end
                    if (TO_LIM != '0 && wait_cnt_d == TO_LIM) begin
                        set_timeout = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (inst_ready) begin
                    fetch_inc    = 1'b1;
                    inst_valid_d = 1'b0;
                    state_d      = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (redirect_valid) begin
            pc_sel      = PC_J_TARGET;
            jump_target = redirect_target;
            case (state_q)
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        deliver = 1'b0;
                        state_d = ST_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        // Counter keeps running so a dead memory is still reported.
                        drop_d = 1'b1;
                    end
                end
                ST_HOLD: begin
                    inst_valid_d = 1'b0;
                    state_d      = ST_REQ;
                end
                default: begin
                    state_d = ST_REQ;
                end
            endcase
        end

        if (deliver) begin
            inst_valid_d = 1'b1;
        end
    end

    assign inst_valid  = inst_valid_q;
    assign inst_data   = inst_data_q;
    assign inst_pc     = inst_pc_q;
    assign timeout_err = timeout_err_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_riscv_fetch_ctrl.sv
// Directed bench for riscv_fetch_ctrl with a tiny PC register model standing in for riscv_pc.
module tb_riscv_fetch_ctrl;
    import riscv_fetch_pkg::*;

    localparam int XLEN = 32;

    logic            clk;
    logic            x_reset;
    logic [XLEN-1:0] pc_in;
    pc_sel_t         pc_sel;
    logic [XLEN-1:0] jump_target;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;
    logic            timeout_err;
    logic [31:0]     fetch_count;

    int n_checks = 0;
    int n_errs   = 0;

    riscv_fetch_ctrl #(.XLEN(XLEN), .TIMEOUT(4)) dut (
        .clk            (clk),
        .x_reset        (x_reset),
        .pc_in          (pc_in),
        .pc_sel         (pc_sel),
        .jump_target    (jump_target),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .timeout_err    (timeout_err),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge x_reset) begin
        if (x_reset) begin
            pc_in <= '0;
        end else begin
            case (pc_sel)
                PC_PLUS4:    pc_in <= pc_in + 32'd1;
                PC_J_TARGET: pc_in <= jump_target;
                default:     pc_in <= pc_in;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        x_reset         = 1'b1;
        imem_req_ready  = 1'b1;
        imem_rsp_valid  = 1'b0;
        imem_rsp_data   = '0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        inst_ready      = 1'b1;

        // Reset state
        #2;
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst_data", inst_data, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        chk("rst_fetch_count", fetch_count, 32'd0);
        chk("rst_pc_sel", 32'(pc_sel), 32'(PC_HOLD));
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        tick();

        // 1: basic fetch
        x_reset = 1'b0;
        settle();
        chk("t1_idle_no_req", 32'(imem_req_valid), 32'd0);
        tick();
        settle();
        chk("t1_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t1_req_addr", imem_req_addr, 32'd0);
        chk("t1_pc_plus4", 32'(pc_sel), 32'(PC_PLUS4));
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0013;
        settle();
        chk("t1_wait_no_req", 32'(imem_req_valid), 32'd0);
        tick();
        imem_rsp_valid = 1'b0;
        settle();
        chk("t1_inst_valid", 32'(inst_valid), 32'd1);
        chk("t1_inst_pc", inst_pc, 32'd0);
        chk("t1_inst_data", inst_data, 32'h0000_0013);
        tick();
        settle();
        chk("t1_fetch_count", fetch_count, 32'd1);
        chk("t1_inst_cleared", 32'(inst_valid), 32'd0);
        chk("t1_req2_valid", 32'(imem_req_valid), 32'd1);
        chk("t1_req2_addr", imem_req_addr, 32'd1);

        // 2: decode backpressure in HOLD
        inst_ready = 1'b0;
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hAAAA_0001;
        tick();
        imem_rsp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("t2_hold_valid", 32'(inst_valid), 32'd1);
            chk("t2_hold_data", inst_data, 32'hAAAA_0001);
            chk("t2_hold_pc", inst_pc, 32'd1);
            chk("t2_hold_pc_sel", 32'(pc_sel), 32'(PC_HOLD));
            chk("t2_hold_no_req", 32'(imem_req_valid), 32'd0);
            chk("t2_hold_count", fetch_count, 32'd1);
            tick();
        end
        inst_ready = 1'b1;
        tick();
        settle();
        chk("t2_count_after", fetch_count, 32'd2);
        chk("t2_req_addr", imem_req_addr, 32'd2);

        // 3: redirect in WAIT, response two cycles later is dropped
        tick();
        redirect_valid  = 1'b1;
        redirect_target = 32'h40;
        settle();
        chk("t3_pc_sel_jt", 32'(pc_sel), 32'(PC_J_TARGET));
        chk("t3_jump_target", jump_target, 32'h40);
        tick();
        redirect_valid  = 1'b0;
        redirect_target = '0;
        settle();
        chk("t3_jt_zero", jump_target, 32'd0);
        chk("t3_pc_sel_hold", 32'(pc_sel), 32'(PC_HOLD));
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid = 1'b0;
        settle();
        chk("t3_dropped", 32'(inst_valid), 32'd0);
        chk("t3_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t3_req_addr", imem_req_addr, 32'h40);
        chk("t3_count", fetch_count, 32'd2);

        // 4: redirect coincident with response
        tick();
        redirect_valid  = 1'b1;
        redirect_target = 32'h80;
        imem_rsp_valid  = 1'b1;
        imem_rsp_data   = 32'h1111_1111;
        settle();
        chk("t4_pc_sel_jt", 32'(pc_sel), 32'(PC_J_TARGET));
        tick();
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        settle();
        chk("t4_no_inst", 32'(inst_valid), 32'd0);
        chk("t4_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t4_req_addr", imem_req_addr, 32'h80);
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h2222_2222;
        tick();
        imem_rsp_valid = 1'b0;
        settle();
        chk("t4_inst_valid", 32'(inst_valid), 32'd1);
        chk("t4_inst_data", inst_data, 32'h2222_2222);
        chk("t4_inst_pc", inst_pc, 32'h80);
        tick();
        settle();
        chk("t4_count", fetch_count, 32'd3);
        chk("t4_req_addr2", imem_req_addr, 32'h81);

        // 5: timeout with TIMEOUT=4
        inst_ready = 1'b0;
        tick();
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("t5_timeout_ramp", 32'(timeout_err), (i == 4) ? 32'd1 : 32'd0);
        end
        tick();
        tick();
        chk("t5_timeout_sticky", 32'(timeout_err), 32'd1);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h3333_3333;
        tick();
        imem_rsp_valid = 1'b0;
        settle();
        chk("t5_late_valid", 32'(inst_valid), 32'd1);
        chk("t5_late_data", inst_data, 32'h3333_3333);
        chk("t5_late_pc", inst_pc, 32'h81);
        chk("t5_still_err", 32'(timeout_err), 32'd1);

        // 6: asynchronous reset in HOLD
        x_reset = 1'b1;
        #1;
        chk("t6_async_valid", 32'(inst_valid), 32'd0);
        chk("t6_async_count", fetch_count, 32'd0);
        chk("t6_async_timeout", 32'(timeout_err), 32'd0);
        chk("t6_async_data", inst_data, 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h4444_4444;
        tick();
        x_reset = 1'b0;
        settle();
        chk("t6_idle_no_req", 32'(imem_req_valid), 32'd0);
        chk("t6_idle_pc_sel", 32'(pc_sel), 32'(PC_HOLD));
        tick();
        imem_rsp_valid = 1'b0;
        settle();
        chk("t6_rsp_ignored", 32'(inst_valid), 32'd0);
        chk("t6_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t6_req_addr", imem_req_addr, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/riscv_fetch_ctrl.md
Name: riscv_fetch_ctrl

Overview:
Instruction-fetch sequencer for the single-cycle-issue core. It drives pc_sel and the jump target into the PC register, and issues one instruction-memory request at a time from the current PC. It buffers the returned word for decode and handles redirects (jumps) arriving at any point in the fetch sequence. The block sits between riscv_pc, instruction memory and decode.

Parameters:
XLEN, 32, address/data width.
TIMEOUT, 255, cycles in WAIT before timeout_err is set; 0 disables the check.

Ports:
clk  in  1  core clock, rising edge.
x_reset  in  1  reset; asynchronous, active-high.
pc_in  in  XLEN  current PC value (word index) from riscv_pc.
pc_sel  out  PC_SEL  PC update select to riscv_pc. The enum is PC_HOLD / PC_PLUS4 / PC_J_TARGET; PC_HOLD is added to riscv_constants.sv.
jump_target  out  XLEN  new PC when pc_sel==PC_J_TARGET.
imem_req_valid  out  1  fetch request.
imem_req_ready  in  1  memory accepts request.
imem_req_addr  out  XLEN  fetch address (= pc_in).
imem_rsp_valid  in  1  response word valid (single-cycle pulse).
imem_rsp_data  in  XLEN  response word.
redirect_valid  in  1  jump request pulse.
redirect_target  in  XLEN  jump destination.
inst_valid  out  1  buffered instruction available to decode.
inst_ready  in  1  decode accepts instruction.
inst_data  out  XLEN  buffered instruction.
inst_pc  out  XLEN  PC of buffered instruction.
timeout_err  out  1  sticky: memory response overdue.
fetch_count  out  32  instructions delivered to decode; wraps at 2^32.

Behaviour:
- Reset (async assert): state=IDLE. inst_valid=0, inst_data=0, inst_pc=0, timeout_err=0, fetch_count=0, wait counter=0. Combinational outputs evaluate to pc_sel=PC_HOLD and imem_req_valid=0.
- States: IDLE, REQ, WAIT, HOLD.
- IDLE: lasts one cycle after reset deassertion, then moves to REQ.
- REQ:
  - imem_req_valid = !redirect_valid.
  - imem_req_addr = pc_in.
  - On handshake (valid && ready): latch req_pc=pc_in, pc_sel=PC_PLUS4 in the same cycle, move to WAIT.
  - Without handshake: stay in REQ with pc_sel=PC_HOLD.
  - Request retraction is permitted only on a redirect cycle.
- WAIT:
  - wait counter increments each cycle.
  - On imem_rsp_valid: inst_data=rsp_data, inst_pc=req_pc, inst_valid=1, move to HOLD, clear the counter.
  - If the counter reaches TIMEOUT (TIMEOUT≠0): timeout_err=1 (sticky until reset), state stays WAIT.
- HOLD:
  - inst_valid=1; inst_data and inst_pc are stable until the handshake.
  - On inst_valid && inst_ready: inst_valid=0, fetch_count+1, move to REQ.
  - Single outstanding request; no fetch-ahead, so fetch throughput is at best 1 instruction per 3 cycles.
- Redirect (redirect_valid=1 in any state) has priority over everything:
  - pc_sel=PC_J_TARGET and jump_target=redirect_target in the same cycle (combinational); riscv_pc loads it at the next edge.
  - jump_target=0 in all other cycles.
  - IDLE or REQ: move to REQ; no request is issued that cycle.
  - WAIT, no response this cycle: set drop flag, stay WAIT. The next response is discarded (no inst_valid), the flag clears, and the state moves to REQ.
  - WAIT with imem_rsp_valid in the same cycle: response discarded, move to REQ, drop flag not set.
  - HOLD: buffer discarded, inst_valid=0 next cycle, move to REQ. If inst_ready is also 1, the handshake counts (fetch_count+1).
- Timeout behaviour during a drop is identical: the counter still runs.
- Reset mid-operation: immediate return to reset values. Any memory response that arrives later is ignored because the state is not WAIT.
- Responses arriving outside WAIT are ignored.

Test Plan:
1. Reset release with pc_in=0, always-ready memory, 1-cycle response 0x00000013, inst_ready=1. Required: req at addr 0, PC_PLUS4 on the handshake, inst_valid with inst_pc=0 and inst_data=0x13, then req at addr 1; fetch_count=1.
2. Backpressure: inst_ready=0 for 5 cycles in HOLD. Required: inst_valid, inst_data and inst_pc stable for all 5 cycles; pc_sel=PC_HOLD; no new request; fetch_count unchanged until ready.
3. Redirect in WAIT to 0x40, response 2 cycles later. Required: pc_sel=PC_J_TARGET and jump_target=0x40 that cycle; response dropped (inst_valid stays 0); next request addr=0x40.
4. Redirect coincident with imem_rsp_valid in WAIT. Required: no inst_valid; next state REQ; the following response is delivered normally (drop flag clear).
5. TIMEOUT=4, memory never responds. Required: timeout_err=1 after the 4th WAIT cycle and stays 1. A later response is still delivered; timeout_err clears only on x_reset.
6. Assert x_reset while in HOLD with inst_valid=1. Required: inst_valid, fetch_count and timeout_err go to 0 immediately (asynchronously); IDLE for one cycle after deassert, then REQ.
